// File: rtl/bu_pkg.sv
// rtl/bu_pkg.sv - shared register-file constants and writeback entry type
package bu_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;

    localparam logic [REG_ADDR_W-1:0] REG_BA = 3'd0;
    localparam logic [REG_ADDR_W-1:0] REG_A1 = 3'd1;
    localparam logic [REG_ADDR_W-1:0] REG_A2 = 3'd2;
    localparam logic [REG_ADDR_W-1:0] REG_A3 = 3'd3;
    localparam logic [REG_ADDR_W-1:0] REG_D0 = 3'd4;
    localparam logic [REG_ADDR_W-1:0] REG_D1 = 3'd5;
    localparam logic [REG_ADDR_W-1:0] REG_D2 = 3'd6;
    localparam logic [REG_ADDR_W-1:0] REG_D3 = 3'd7;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - writeback request, register-port and pending-query bundle
interface reg_writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              register_write;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;

    logic [ADDR_W-1:0] query1;
    logic [ADDR_W-1:0] query2;
    logic              busy1;
    logic              busy2;

    logic [CNT_W-1:0]  count;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output query1, query2,
        input  mem_ready, alu_ready,
        input  register_write, write_address, write_data,
        input  busy1, busy2, count
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  query1, query2,
        output mem_ready, alu_ready,
        output register_write, write_address, write_data,
        output busy1, busy2, count
    );

endinterface

// File: rtl/reg_writeback_queue_fifo.sv
// rtl/reg_writeback_queue_fifo.sv - pointer/count FIFO exposing every slot and its occupancy
module wb_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 19,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] entries [DEPTH],
    output logic [DEPTH-1:0] occupied
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] offset;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[head_q];

    // Next-state: guarded push at tail, pop at head, count tracks the net change.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        do_push = push && !full;
        do_pop  = pop && !empty;
        if (do_push) begin
            mem_d[tail_q] = wdata;
            tail_d        = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    always_comb begin
        occupied = '0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PTR_W'(i) - head_q;
            occupied[i] = ({1'b0, offset} < count_q);
            entries[i]  = mem_q[i];
        end
    end

    // State register; reset empties the queue and clears storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - arbitrates ALU/memory writebacks into a FIFO retiring one register write per cycle
module reg_writeback_queue
    import bu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_writeback_queue_if.slave  bus
);

    localparam int WIDTH = ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             fifo_push;
    logic [WIDTH-1:0] fifo_wdata;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [WIDTH-1:0] fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_occupied;

    logic             mem_ready;
    logic             alu_ready;
    logic             mem_fire;
    logic             alu_fire;
    logic             retire;
    logic             busy1;
    logic             busy2;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .wdata    (fifo_wdata),
        .pop      (fifo_pop),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count),
        .entries  (fifo_entries),
        .occupied (fifo_occupied)
    );

    // Memory loads win arbitration; readiness looks only at registered occupancy.
    always_comb begin
        mem_ready  = !reset && !fifo_full;
        alu_ready  = !reset && !fifo_full && !bus.mem_valid;
        mem_fire   = bus.mem_valid && mem_ready;
        alu_fire   = bus.alu_valid && alu_ready;
        fifo_push  = mem_fire || alu_fire;
        fifo_wdata = mem_fire ? {bus.mem_addr, bus.mem_data}
                              : {bus.alu_addr, bus.alu_data};
        retire     = !reset && !fifo_empty;
        fifo_pop   = retire;
    end

    // Pending-write lookup over live entries only; offered requests are not visible yet.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_occupied[i] && (fifo_entries[i][WIDTH-1 -: ADDR_W] == bus.query1)) begin
                busy1 = 1'b1;
            end
            if (fifo_occupied[i] && (fifo_entries[i][WIDTH-1 -: ADDR_W] == bus.query2)) begin
                busy2 = 1'b1;
            end
        end
        busy1 = busy1 && !reset;
        busy2 = busy2 && !reset;
    end

    assign bus.mem_ready      = mem_ready;
    assign bus.alu_ready      = alu_ready;
    assign bus.register_write = retire;
    assign bus.write_address  = retire ? fifo_rdata[WIDTH-1 -: ADDR_W] : '0;
    assign bus.write_data     = retire ? fifo_rdata[DATA_W-1:0] : '0;
    assign bus.busy1          = busy1;
    assign bus.busy2          = busy2;
    assign bus.count          = reset ? '0 : fifo_count;

endmodule
